// File: rtl/bpsk_ctrl_pkg.sv
// Shared types and constants for the BPSK burst sequencer.
package bpsk_ctrl_pkg;

  // Burst phase; while busy it names the phase of the next symbol to be issued.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PAY   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // PN9 generator x^9 + x^5 + 1, Fibonacci form shifting toward the MSB.
  localparam logic [8:0]  PN9_SEED   = 9'h1FF;
  localparam int unsigned PN9_TAP_HI = 8;
  localparam int unsigned PN9_TAP_LO = 4;

  // FIR input codes.
  localparam logic [1:0] FIR_POS  = 2'b01;
  localparam logic [1:0] FIR_NEG  = 2'b11;
  localparam logic [1:0] FIR_ZERO = 2'b00;

  // Map a presented symbol onto the FIR input code.
  function automatic logic [1:0] fir_code(input logic zero, input logic pol);
    if (zero) return FIR_ZERO;
    return pol ? FIR_POS : FIR_NEG;
  endfunction

endpackage

// File: rtl/bpsk_pn9_gen.sv
// PN9 payload source: reload to the seed on request, advance one bit per shift.
module bpsk_pn9_gen
  import bpsk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic bit_out
);

  logic [8:0] lfsr;

  // LFSR register with seed reload taking priority over shifting.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= PN9_SEED;
    end else if (shift) begin
      lfsr <= {lfsr[7:0], lfsr[PN9_TAP_HI] ^ lfsr[PN9_TAP_LO]};
    end
  end

  assign bit_out = lfsr[PN9_TAP_HI];

endmodule

// File: rtl/bpsk_burst_ctrl.sv
// BPSK burst sequencer: preamble, handshaked payload, zero flush, DAC gating.
// Build option BURST_PN9_EN replaces the external payload handshake with an
// internal PN9 source seeded on every accepted start.
module bpsk_burst_ctrl
  import bpsk_ctrl_pkg::*;
#(
  parameter int unsigned SYM_DIV   = 16,
  parameter int unsigned PRE_LEN   = 32,
  parameter int unsigned PAY_LEN   = 256,
  parameter int unsigned FLUSH_LEN = 24,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic pay_bit,
  input  logic pay_valid,
  output logic pay_ready,
  output logic sym_stb,
  output logic sym_bit,
  output logic sym_zero,
  output logic dac_en,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int unsigned DIV_W = $clog2(SYM_DIV);

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               stb_nxt, bit_nxt, zero_nxt, dac_nxt, busy_nxt, done_nxt, und_nxt;
  logic               accept, pay_slot;
  logic               src_bit, src_ok;

  // A start is taken only from a quiet IDLE (not aborted, not the done cycle).
  assign accept   = (state == IDLE) && start && !abort && !done;
  // The cycle before a payload strobe is where the payload bit is taken.
  assign pay_slot = (state == PAY) && (div == '0) && !abort;

`ifdef BURST_PN9_EN
  logic pn9_bit;
  logic unused_pay;

  bpsk_pn9_gen u_pn9 (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (pay_slot),
    .bit_out (pn9_bit)
  );

  assign unused_pay = pay_bit ^ pay_valid;
  assign pay_ready  = 1'b0;
  assign src_ok     = 1'b1;
  assign src_bit    = pn9_bit;
`else
  assign pay_ready  = pay_slot;
  assign src_ok     = pay_valid;
  assign src_bit    = pay_bit;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    cnt_nxt   = cnt;
    stb_nxt   = 1'b0;
    bit_nxt   = sym_bit;
    zero_nxt  = sym_zero;
    dac_nxt   = dac_en;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    und_nxt   = underrun;

    if ((state != IDLE) && abort) begin
      state_nxt = IDLE;
      div_nxt   = '0;
      cnt_nxt   = '0;
      bit_nxt   = 1'b0;
      zero_nxt  = 1'b0;
      dac_nxt   = 1'b0;
      busy_nxt  = 1'b0;
    end else if (accept) begin
      // First preamble symbol goes out immediately.
      stb_nxt  = 1'b1;
      bit_nxt  = 1'b1;
      zero_nxt = 1'b0;
      dac_nxt  = 1'b1;
      busy_nxt = 1'b1;
      und_nxt  = 1'b0;
      div_nxt  = DIV_W'(1);
      if (PRE_LEN == 1) begin
        state_nxt = PAY;
        cnt_nxt   = '0;
      end else begin
        state_nxt = PRE;
        cnt_nxt   = CNT_W'(1);
      end
    end else if (state != IDLE) begin
      div_nxt = (div == DIV_W'(SYM_DIV - 1)) ? '0 : div + DIV_W'(1);
      if (div == '0) begin
        case (state)
          PRE: begin
            stb_nxt  = 1'b1;
            bit_nxt  = ~cnt[0];
            zero_nxt = 1'b0;
            if (cnt == CNT_W'(PRE_LEN - 1)) begin
              state_nxt = PAY;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          PAY: begin
            stb_nxt  = 1'b1;
            bit_nxt  = src_ok ? src_bit : 1'b0;
            zero_nxt = 1'b0;
            if (!src_ok) und_nxt = 1'b1;
            if (cnt == CNT_W'(PAY_LEN - 1)) begin
              state_nxt = FLUSH;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          FLUSH: begin
            // cnt == FLUSH_LEN marks the end of the last flush symbol period.
            if (cnt == CNT_W'(FLUSH_LEN)) begin
              state_nxt = IDLE;
              div_nxt   = '0;
              cnt_nxt   = '0;
              bit_nxt   = 1'b0;
              zero_nxt  = 1'b0;
              dac_nxt   = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              stb_nxt  = 1'b1;
              bit_nxt  = 1'b0;
              zero_nxt = 1'b1;
              cnt_nxt  = cnt + CNT_W'(1);
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      cnt      <= '0;
      sym_stb  <= 1'b0;
      sym_bit  <= 1'b0;
      sym_zero <= 1'b0;
      dac_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      div      <= div_nxt;
      cnt      <= cnt_nxt;
      sym_stb  <= stb_nxt;
      sym_bit  <= bit_nxt;
      sym_zero <= zero_nxt;
      dac_en   <= dac_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      underrun <= und_nxt;
    end
  end

endmodule

// File: tb/tb_bpsk_burst_ctrl.sv
// Bench for bpsk_burst_ctrl: per-cycle behavioural model plus literal pins.
module tb_bpsk_burst_ctrl;

  localparam int SYM_DIV = 4;
  localparam int PRE     = 4;
  localparam int PAY     = 8;
  localparam int FL      = 2;
  localparam int NSYM    = PRE + PAY + FL;

  localparam int K_NOM = 0, K_UND = 1, K_ABT = 2, K_BSY = 3, K_SA = 4, K_RST = 5;

  logic clk = 1'b0;
  logic rst, start, abort, pay_bit, pay_valid;
  logic pay_ready, sym_stb, sym_bit, sym_zero, dac_en, busy, done, underrun;

  logic [7:0] pay_word = 8'h00;
  logic       drop_en  = 1'b0;
  logic [3:0] hs       = 4'd0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bpsk_burst_ctrl #(
    .SYM_DIV(SYM_DIV), .PRE_LEN(PRE), .PAY_LEN(PAY), .FLUSH_LEN(FL), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pay_bit(pay_bit), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .sym_stb(sym_stb), .sym_bit(sym_bit), .sym_zero(sym_zero),
    .dac_en(dac_en), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Payload source: bit index follows handshake count; optional drop of the 3rd.
  always @(posedge clk) begin
    if (start) hs <= 4'd0;
    else if (pay_ready) hs <= hs + 4'd1;
  end
  assign pay_bit   = pay_word[3'd7 - hs[2:0]];
  assign pay_valid = !(drop_en && hs == 4'd2);

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference PN9 output sequence: s[n+9] = s[n] ^ s[n+4], s[0..8] = 1.
  bit pn[0:31];
  initial begin
    for (int i = 0; i < 9; i++) pn[i] = 1'b1;
    for (int n = 0; n + 9 < 32; n++) pn[n+9] = pn[n] ^ pn[n+4];
  end

  // Behavioural model: a burst is an age counter from its first strobe cycle.
  bit m_active = 1'b0, m_und = 1'b0, m_done = 1'b0;
  int m_age = 0;
  bit m_pay[0:PAY-1];
  bit e_busy, e_stb, e_zero, e_bit, e_ready;
  int k, ph;

  always @(negedge clk) begin
    e_busy = m_active; e_stb = 0; e_zero = 0; e_bit = 0; e_ready = 0;
    k = m_age / SYM_DIV; ph = m_age % SYM_DIV;
    if (m_active) begin
      e_stb  = (ph == 0);
      e_zero = (k >= PRE + PAY);
      if (k < PRE) e_bit = (k % 2 == 0);
      else if (k < PRE + PAY) e_bit = m_pay[k-PRE];
      e_ready = (ph == SYM_DIV - 1) && (k + 1 >= PRE) && (k + 1 < PRE + PAY) && !abort;
    end
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("dac_en", dac_en, e_busy);
      chk("sym_stb", sym_stb, e_stb);
      chk("sym_zero", sym_zero, e_zero);
      chk("sym_bit", sym_bit, e_bit);
      chk("done", done, m_done);
      chk("underrun", underrun, m_und);
`ifdef BURST_PN9_EN
      chk("pay_ready", pay_ready, 1'b0);
`else
      chk("pay_ready", pay_ready, e_ready);
`endif
    end
    // Advance the model with the inputs present during this cycle.
    if (rst) begin
      m_active = 0; m_und = 0; m_done = 0; m_age = 0;
    end else if (m_active && abort) begin
      m_active = 0; m_done = 0;
    end else if (!m_active) begin
      if (start && !abort && !m_done) begin
        m_active = 1; m_age = 0; m_und = 0;
      end
      m_done = 0;
    end else begin
      if ((ph == SYM_DIV - 1) && (k + 1 >= PRE) && (k + 1 < PRE + PAY)) begin
`ifdef BURST_PN9_EN
        m_pay[k+1-PRE] = pn[k+1-PRE];
`else
        m_pay[k+1-PRE] = pay_valid ? pay_bit : 1'b0;
        if (!pay_valid) m_und = 1;
`endif
      end
      m_age++;
      m_done = 0;
      if (m_age == NSYM * SYM_DIV) begin
        m_active = 0; m_done = 1;
      end
    end
  end

  task automatic run_burst(input int kind, input logic [7:0] word, input bit drop, input int len);
    int nstb, ndone, ngap;
    logic [7:0] w;
    nstb = 0; ndone = 0; ngap = 0;
    w = word;
    pay_word = word;
    drop_en  = drop;
    for (int rel = 0; rel < len; rel++) begin
      start = (rel == 0) || (kind == K_BSY && (rel == 10 || rel == 57)) || (kind == K_ABT && rel == 25);
      abort = (kind == K_ABT && rel == 20) || (kind == K_SA && rel == 0);
      rst   = (kind == K_RST && rel == 30);
      @(negedge clk);
      if (sym_stb) nstb++;
      if (done) ndone++;
      if (kind == K_NOM) begin
        if (rel == 0) chk("nom_idle_busy", busy, 1'b0);
        if (rel == 1) begin
          chk("nom_first_stb", sym_stb, 1'b1);
          chk("nom_first_busy", busy, 1'b1);
          chk("nom_first_dac", dac_en, 1'b1);
          chk("nom_first_bit", sym_bit, 1'b1);
          chk("nom_und_clear", underrun, 1'b0);
        end
        if (rel == 5) chk("nom_pre1_bit", sym_bit, 1'b0);
        if (rel >= 17 && rel <= 45 && (rel - 17) % 4 == 0) begin
`ifdef BURST_PN9_EN
          chk("pn9_pay_bit", sym_bit, 1'b1);
`else
          chk("nom_pay_bit", sym_bit, w[7 - (rel - 17) / 4]);
`endif
        end
        if (rel == 49) chk("nom_flush0_zero", sym_zero, 1'b1);
        if (rel == 53) begin
          chk("nom_flush1_zero", sym_zero, 1'b1);
          chk("nom_flush1_stb", sym_stb, 1'b1);
        end
        if (rel == 56) chk("nom_pre_done_dac", dac_en, 1'b1);
        if (rel == 57) begin
          chk("nom_done", done, 1'b1);
          chk("nom_done_dac", dac_en, 1'b0);
          chk("nom_done_busy", busy, 1'b0);
          chk("nom_done_zero", sym_zero, 1'b0);
          chk("nom_done_und", underrun, 1'b0);
        end
        if (rel == 58) chk("nom_done_pulse", done, 1'b0);
      end
      if (kind == K_UND) begin
`ifdef BURST_PN9_EN
        if (rel == 57) chk("pn9_no_und", underrun, 1'b0);
`else
        if (rel == 21) chk("und_pay1_bit", sym_bit, 1'b1);
        if (rel == 24) chk("und_before", underrun, 1'b0);
        if (rel == 25) chk("und_pay2_bit", sym_bit, 1'b0);
        if (rel == 26) chk("und_set", underrun, 1'b1);
        if (rel == 57) begin
          chk("und_held_done", underrun, 1'b1);
          chk("und_done", done, 1'b1);
        end
`endif
      end
      if (kind == K_ABT) begin
        if (rel == 20) chk("abt_ready_low", pay_ready, 1'b0);
        if (rel == 21) begin
          chk("abt_busy", busy, 1'b0);
          chk("abt_dac", dac_en, 1'b0);
          chk("abt_stb", sym_stb, 1'b0);
        end
        if (rel >= 21 && rel <= 25 && sym_stb) ngap++;
        if (rel == 26) begin
          chk("abt_restart_stb", sym_stb, 1'b1);
          chk("abt_restart_busy", busy, 1'b1);
        end
        if (rel == 82) chk("abt_restart_done", done, 1'b1);
      end
      if (kind == K_BSY) begin
        if (rel == 57) chk("bsy_done", done, 1'b1);
        if (rel == 58) chk("bsy_start_at_done", busy, 1'b0);
        if (rel == 59) chk("bsy_still_idle", busy, 1'b0);
      end
      if (kind == K_SA && rel == 1) begin
        chk("sa_busy", busy, 1'b0);
        chk("sa_stb", sym_stb, 1'b0);
      end
      if (kind == K_RST) begin
`ifndef BURST_PN9_EN
        if (rel == 26) chk("rst_und_before", underrun, 1'b1);
`endif
        if (rel == 31) begin
          chk("rst_busy", busy, 1'b0);
          chk("rst_dac", dac_en, 1'b0);
          chk("rst_stb", sym_stb, 1'b0);
          chk("rst_bit", sym_bit, 1'b0);
          chk("rst_zero", sym_zero, 1'b0);
          chk("rst_done", done, 1'b0);
          chk("rst_und", underrun, 1'b0);
          chk("rst_ready", pay_ready, 1'b0);
        end
      end
      @(posedge clk);
      #1;
    end
    start = 0; abort = 0; rst = 0;
    if (kind == K_NOM || kind == K_BSY) begin
      chk_int("burst_strobes", nstb, NSYM);
      chk_int("burst_dones", ndone, 1);
    end
    if (kind == K_ABT) begin
      chk_int("abt_gap_strobes", ngap, 0);
      chk_int("abt_dones", ndone, 1);
    end
    if (kind == K_SA) chk_int("sa_strobes", nstb, 0);
    if (kind == K_RST) chk_int("rst_dones", ndone, 0);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_dac", dac_en, 1'b0);
    chk("reset_stb", sym_stb, 1'b0);
    chk("reset_und", underrun, 1'b0);
    chk("reset_done", done, 1'b0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    run_burst(K_NOM, 8'b1100_1010, 1'b0, 60);
    run_burst(K_UND, 8'hFF,        1'b1, 60);
    run_burst(K_NOM, 8'b1100_1010, 1'b0, 60);
    run_burst(K_ABT, 8'b0110_1001, 1'b0, 86);
    run_burst(K_BSY, 8'b1010_0101, 1'b0, 62);
    run_burst(K_SA,  8'hFF,        1'b0, 6);
    run_burst(K_RST, 8'hFF,        1'b1, 40);
    run_burst(K_NOM, 8'b0011_0101, 1'b0, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpsk_burst_ctrl.md
Name: bpsk_burst_ctrl

Overview:
- Burst sequencer for the BPSK transmit path.
- Paces symbols at clk/SYM_DIV into the root-raised-cosine shaping filter.
- Each burst is a fixed alternating preamble, then a handshaked payload, then zero-symbol flush of the filter tail.
- Gates the DAC write/clock enable (data_en) so the DACs only run while a burst is in flight. Sits between the bit source and the FIR input in the 50 MHz domain.

Parameters:
- SYM_DIV, 16, clk cycles per symbol (>=2).
- PRE_LEN, 32, preamble symbols (>=1).
- PAY_LEN, 256, payload symbols (>=1).
- FLUSH_LEN, 24, zero symbols appended to drain the FIR (>=1).
- CNT_W, 16, width of the symbol counter; must hold max(PRE_LEN, PAY_LEN, FLUSH_LEN).

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle burst request; honoured only in IDLE
- abort  in  1  one-cycle cancel; honoured in any state
- pay_bit  in  1  payload bit from source
- pay_valid  in  1  pay_bit valid
- pay_ready  out  1  payload bit consumed this cycle
- sym_stb  out  1  one-cycle strobe: new symbol presented
- sym_bit  out  1  symbol polarity (1 -> +1, 0 -> -1); held between strobes
- sym_zero  out  1  symbol is zero (flush); FIR input forced to 2'b00
- dac_en  out  1  DAC write/clock enable (data_en)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse on normal burst completion
- underrun  out  1  sticky: payload bit missing at a payload strobe

Behaviour:
- Reset: state IDLE; all outputs 0; divider and counters 0; underrun cleared.
- States: IDLE, PRE, PAY, FLUSH.
- Outputs: all registered except pay_ready.
- pay_ready is combinational = (state==PAY) && (div==0) && !abort.
- Strobe timing:
  - start in IDLE at cycle 0 -> cycle 1: state PRE, busy=1, dac_en=1, sym_stb=1, symbol 0 presented.
  - Symbol k strobes at cycle 1+k*SYM_DIV; the divider counts 0..SYM_DIV-1 and wraps.
- PRE: symbol i has sym_bit = ~i[0] (1,0,1,0,...); sym_zero=0. After PRE_LEN symbols -> PAY.
- PAY:
  - At each payload strobe cycle pay_ready=1.
  - If pay_valid=1: sym_bit = pay_bit, consumed.
  - If pay_valid=0: sym_bit=0, underrun<=1, burst continues; no retry.
  - After PAY_LEN symbols -> FLUSH.
- FLUSH: sym_zero=1, sym_bit=0 for FLUSH_LEN symbols.
- Completion: N = PRE_LEN+PAY_LEN+FLUSH_LEN. At cycle 1+N*SYM_DIV: state IDLE, done=1 for one cycle, busy=0, dac_en=0, sym_zero=0.
- start while busy is ignored; a start in the same cycle as done's assertion is also ignored. A new start is accepted the cycle after the return to IDLE.
- abort in PRE/PAY/FLUSH:
  - Next cycle: IDLE, busy=0, dac_en=0, sym_zero=0, sym_bit=0, no done, no strobe.
  - underrun keeps its value; pay_ready is 0 in the abort cycle.
- abort and start together in IDLE: abort wins, stay IDLE.
- underrun clears on rst or on an accepted start.
- rst mid-burst: same as the reset state next cycle; no done.
- Counters never wrap past their length; the divider wraps at SYM_DIV-1.

Optional Feature:
- Macro: BURST_PN9_EN.
- Defined:
  - Payload comes from an internal PN9 LFSR (x^9+x^5+1), seeded 9'h1FF on every accepted start.
  - Output bit = lfsr[8]; the LFSR shifts once per payload strobe.
  - pay_ready tied 0; pay_valid and pay_bit ignored; underrun never set.
- Undefined: external handshake as above.

Decomposition:
- Package bpsk_ctrl_pkg:
  - state encoding typedef (IDLE/PRE/PAY/FLUSH);
  - PN9 seed 9'h1FF and tap positions;
  - FIR input codes (+1 = 2'b01, -1 = 2'b11, 0 = 2'b00).
- One natural sub-module: bpsk_pn9_gen (seed-load, shift-enable, bit output), instantiated only under BURST_PN9_EN.

Test Plan:
- Bench parameters: SYM_DIV=4, PRE_LEN=4, PAY_LEN=8, FLUSH_LEN=2.
- Nominal burst: start at cycle 0, pay_valid=1, payload 8'b1100_1010 MSB first ->
  - strobes at cycles 1,5,...,53;
  - sym_bit 1,0,1,0 then 1,1,0,0,1,0,1,0;
  - sym_zero=1 at cycles 49 and 53;
  - done=1 and dac_en=0 at cycle 57; underrun=0.
- Underrun: pay_valid=0 only at the 3rd payload strobe -> that symbol has sym_bit=0; underrun=1 from the next cycle through done; the next start clears it.
- Abort mid-PAY: abort at cycle 20 -> cycle 21: busy=0, dac_en=0, no further strobes, done never asserted; start at cycle 25 begins a fresh burst, first strobe at cycle 26.
- Start while busy: start at cycles 0 and 10 -> single burst, done only at 57. Start together with abort in IDLE -> no burst.
- Reset: rst asserted at cycle 30 for one cycle -> all outputs 0 at cycle 31, including underrun.
- BURST_PN9_EN: nominal burst -> first 8 payload sym_bits all 1 (seed 1FF); pay_ready stays 0 throughout; underrun stays 0.
